instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage that sits directly upstream of program_memory and downstream-feeds decode. It owns the architectural fetch PC and drives the memory's request/ack handshake. Returned instructions are captured with their PC into a small in-order buffer that decouples memory latency from decode back-pressure. It also handles redirects (branch/jump/trap targets) and flags misaligned targets.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset.
BUF_DEPTH, 2, instruction buffer entries (power of two, >= 2).

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst_n  input  1  asynchronous, active-low reset.
o_pc  output  32  fetch address to program memory.
o_instruction_request  output  1  fetch request to program memory.
i_instruction  input  32  instruction word from program memory.
i_ack  input  1  program memory acknowledge; may arrive in the same cycle as the request.
i_redirect  input  1  redirect strobe from execute/trap logic.
i_redirect_pc  input  32  redirect target.
i_ready  input  1  decode accepts the current output this cycle.
o_inst_valid  output  1  buffer head holds a valid instruction.
o_inst  output  32  instruction at buffer head.
o_inst_pc  output  32  PC of instruction at buffer head.
o_fetch_fault  output  1  misaligned redirect target; sticky until the next aligned redirect.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - o_pc=RESET_PC.
  - buffer emptied (count=0).
  - o_inst_valid=0, o_inst=0, o_inst_pc=0, o_fetch_fault=0.
  - o_instruction_request=0 while reset is asserted.
- States:
  - FETCH: normal operation.
  - FAULT: fetch halted.
  - Leaves reset into FETCH.
- Request rule:
  - o_instruction_request = (state==FETCH) && (count < BUF_DEPTH) && !i_redirect.
  - Combinational from registered state plus i_redirect only; no dependence on i_ready.
- Request hold:
  - While the request is high and i_ack is low, o_pc is held stable. No timeout.
- Accept:
  - On an edge where request && i_ack, push {i_instruction, o_pc} and set o_pc <= o_pc + 4.
  - Addition is modulo 2^32; 0xFFFF_FFFC wraps to 0x0.
- Stray ack:
  - i_ack without request is ignored; no push, no PC change.
- Output:
  - o_inst_valid = (count != 0); o_inst/o_inst_pc show the head entry.
  - Pop on o_inst_valid && i_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - Throughput: one instruction per cycle with zero-latency ack and i_ready=1.
- Full:
  - At count==BUF_DEPTH the request drops; it resumes the cycle after a pop.
- Redirect (priority over everything except reset):
  - Buffer flushed to count=0; any same-cycle ack or pop discarded.
  - o_pc <= i_redirect_pc.
  - Next cycle: o_inst_valid=0, request asserted at the new PC.
  - If i_redirect_pc[1:0] != 0: enter FAULT, o_fetch_fault<=1, o_pc still loaded (for diagnostics), request stays 0.
- FAULT:
  - No requests, buffer empty; remains until i_redirect with an aligned target.
  - That redirect returns to FETCH and clears o_fetch_fault on the same edge.
- Buffer behaviour:
  - Strict FIFO order; never duplicates or drops an acked instruction except on redirect or reset.
- Reset mid-operation:
  - Same as reset; any outstanding request is abandoned.
  - The first request after release is at RESET_PC.

Test Plan:
1. Release reset (RESET_PC=0), memory acks every request same cycle, i_ready=1 -> o_pc steps 0x0,0x4,0x8…; o_inst_pc sequence 0x0,0x4,0x8 on consecutive cycles, first valid one cycle after release.
2. i_ready=0 from the start -> two entries (pc 0x0, 0x4) buffered, request drops with o_pc=0x8; raise i_ready -> 0x0 then 0x4 delivered in order, request resumes, 0x8 follows without gap.
3. Ack delayed 3 cycles on pc 0x4 -> o_pc stays 0x4 and request stays high for all 3 cycles; exactly one entry with pc 0x4 is pushed.
4. Buffer full, redirect to 0x100 in a cycle where ack and i_ready are also high -> next cycle o_inst_valid=0, o_pc=0x100; the acked word is not delivered; the next output has pc 0x100.
5. Redirect to 0x102 -> o_fetch_fault=1, request 0 for 10+ cycles, o_inst_valid=0; redirect to 0x200 -> fault clears on the same edge, fetch resumes at 0x200.
6. Assert i_rst_n low mid-stream with buffer half full -> outputs go to reset values immediately (asynchronously); after release the first request is at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: program-memory request/ack, redirect input, and the decode-side
// instruction stream. The fetch unit uses the master view and its environment the slave view.
interface instruction_fetch_if;
  logic [31:0] o_pc;
  logic        o_instruction_request;
  logic [31:0] i_instruction;
  logic        i_ack;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_ready;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_fetch_fault;

  modport master (
    output o_pc, o_instruction_request, o_inst_valid, o_inst, o_inst_pc, o_fetch_fault,
    input  i_instruction, i_ack, i_redirect, i_redirect_pc, i_ready
  );

  modport slave (
    input  o_pc, o_instruction_request, o_inst_valid, o_inst, o_inst_pc, o_fetch_fault,
    output i_instruction, i_ack, i_redirect, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, handshakes with program memory and queues
// {instruction, pc} pairs in a small in-order buffer toward decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  instruction_fetch_if.master  bus
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic {FETCH, FAULT} state_t;

  state_t         state;
  logic [31:0]    pc;
  logic           fault;
  logic [CW-1:0]  count;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [31:0]    buf_inst [BUF_DEPTH];
  logic [31:0]    buf_pc   [BUF_DEPTH];

  logic req, push, pop;

  // Gated by the reset pin so the request is low for the whole reset interval.
  assign req  = i_rst_n && (state == FETCH) && (count < CW'(BUF_DEPTH)) && !bus.i_redirect;
  assign push = req && bus.i_ack;
  assign pop  = (count != '0) && bus.i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      fault  <= 1'b0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (bus.i_redirect) begin
      // Flush wins over any same-cycle ack or pop; a misaligned target is kept in pc for debug.
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      pc     <= bus.i_redirect_pc;
      if (bus.i_redirect_pc[1:0] != 2'b00) begin
        state <= FAULT;
        fault <= 1'b1;
      end else begin
        state <= FETCH;
        fault <= 1'b0;
      end
    end else begin
      if (push) begin
        buf_inst[wr_ptr] <= bus.i_instruction;
        buf_pc[wr_ptr]   <= pc;
        wr_ptr           <= wr_ptr + PW'(1);
        pc               <= pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.o_pc                  = pc;
  assign bus.o_instruction_request = req;
  assign bus.o_inst_valid          = (count != '0);
  assign bus.o_inst                = buf_inst[rd_ptr];
  assign bus.o_inst_pc             = buf_pc[rd_ptr];
  assign bus.o_fetch_fault         = fault;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stimulus pushes expected {pc, inst} into a
// scoreboard queue; a forked monitor pops and compares on every decode handshake.
module tb_instruction_fetch;
  localparam logic [31:0] K = 32'hC0DE_0000;  // memory returns pc ^ K

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic ack_en = 1'b0;
  logic stray_ack = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_q[$];

  instruction_fetch_if bus();

  instruction_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  assign bus.i_ack         = (bus.o_instruction_request && ack_en) || stray_ack;
  assign bus.i_instruction = bus.o_pc ^ K;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic reset_dut(input logic rdy, input logic ack);
    i_rst_n = 1'b0;
    bus.i_redirect = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_ready = rdy;
    ack_en = ack;
    stray_ack = 1'b0;
    @(negedge i_clk);
    chk("rst_pc", bus.o_pc, 32'h0);
    chk("rst_req", 32'(bus.o_instruction_request), 32'h0);
    chk("rst_valid", 32'(bus.o_inst_valid), 32'h0);
    chk("rst_fault", 32'(bus.o_fetch_fault), 32'h0);
    step();
    i_rst_n = 1'b1;
  endtask

  initial begin
    bus.i_redirect = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_ready = 1'b0;

    fork
      forever begin
        @(negedge i_clk);
        if (bus.o_inst_valid && bus.i_ready && !bus.i_redirect) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra got pc=%h want=none t=%0t", bus.o_inst_pc, $time);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("sb_pc", bus.o_inst_pc, e);
            chk("sb_inst", bus.o_inst, e ^ K);
          end
        end
      end
    join_none

    // 1: streaming, same-cycle ack, decode always ready
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    reset_dut(1'b1, 1'b1);
    chk("rst_inst", bus.o_inst, 32'h0);
    chk("rst_inst_pc", bus.o_inst_pc, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      chk("t1_pc", bus.o_pc, 32'(i * 4));
      chk("t1_req", 32'(bus.o_instruction_request), 32'h1);
      step();
    end
    ack_en = 1'b0;
    @(negedge i_clk);
    chk("t1_hold_pc", bus.o_pc, 32'h20);
    step();

    // 2: decode stalled, buffer fills then drains in order
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    reset_dut(1'b0, 1'b1);
    step(); step();
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      chk("t2_full_req", 32'(bus.o_instruction_request), 32'h0);
      chk("t2_full_pc", bus.o_pc, 32'h8);
      chk("t2_head_pc", bus.o_inst_pc, 32'h0);
      step();
    end
    bus.i_ready = 1'b1;
    @(negedge i_clk);
    chk("t2_req_a", 32'(bus.o_instruction_request), 32'h0);
    step();
    @(negedge i_clk);
    chk("t2_req_b", 32'(bus.o_instruction_request), 32'h1);
    chk("t2_pc_b", bus.o_pc, 32'h8);
    step();
    ack_en = 1'b0;
    @(negedge i_clk);
    chk("t2_nogap", 32'(bus.o_inst_valid), 32'h1);
    step();
    @(negedge i_clk);
    chk("t2_drained", 32'(bus.o_inst_valid), 32'h0);
    step();

    // 3: ack on pc 0x4 delayed three cycles
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    reset_dut(1'b1, 1'b1);
    step();
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("t3_hold_pc", bus.o_pc, 32'h4);
      chk("t3_hold_req", 32'(bus.o_instruction_request), 32'h1);
      step();
    end
    ack_en = 1'b1;
    @(negedge i_clk);
    chk("t3_ack_pc", bus.o_pc, 32'h4);
    step();
    @(negedge i_clk);
    chk("t3_next_pc", bus.o_pc, 32'h8);
    step();
    ack_en = 1'b0;
    step();

    // 4: redirect while full with ack and ready high
    reset_dut(1'b0, 1'b1);
    step(); step(); step();
    bus.i_redirect = 1'b1;
    bus.i_redirect_pc = 32'h100;
    bus.i_ready = 1'b1;
    exp_q.push_back(32'h100);
    @(negedge i_clk);
    chk("t4_redir_req", 32'(bus.o_instruction_request), 32'h0);
    step();
    bus.i_redirect = 1'b0;
    @(negedge i_clk);
    chk("t4_flushed", 32'(bus.o_inst_valid), 32'h0);
    chk("t4_pc", bus.o_pc, 32'h100);
    chk("t4_req", 32'(bus.o_instruction_request), 32'h1);
    step();
    ack_en = 1'b0;
    @(negedge i_clk);
    chk("t4_first_pc", bus.o_inst_pc, 32'h100);
    step();

    // 5: misaligned redirect faults; stray acks ignored; aligned redirect recovers
    bus.i_redirect = 1'b1;
    bus.i_redirect_pc = 32'h102;
    @(negedge i_clk);
    chk("t5_pre_fault", 32'(bus.o_fetch_fault), 32'h0);
    step();
    bus.i_redirect = 1'b0;
    stray_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      chk("t5_fault", 32'(bus.o_fetch_fault), 32'h1);
      chk("t5_req", 32'(bus.o_instruction_request), 32'h0);
      chk("t5_valid", 32'(bus.o_inst_valid), 32'h0);
      chk("t5_pc", bus.o_pc, 32'h102);
      step();
    end
    stray_ack = 1'b0;
    bus.i_redirect = 1'b1;
    bus.i_redirect_pc = 32'h200;
    ack_en = 1'b1;
    exp_q.push_back(32'h200);
    @(negedge i_clk);
    chk("t5_fault_hold", 32'(bus.o_fetch_fault), 32'h1);
    step();
    bus.i_redirect = 1'b0;
    @(negedge i_clk);
    chk("t5_cleared", 32'(bus.o_fetch_fault), 32'h0);
    chk("t5_resume_pc", bus.o_pc, 32'h200);
    chk("t5_resume_req", 32'(bus.o_instruction_request), 32'h1);
    step();
    ack_en = 1'b0;
    @(negedge i_clk);
    chk("t5_out_pc", bus.o_inst_pc, 32'h200);
    step();

    // PC wrap past 0xFFFF_FFFC
    bus.i_redirect = 1'b1;
    bus.i_redirect_pc = 32'hFFFF_FFFC;
    ack_en = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    step();
    bus.i_redirect = 1'b0;
    @(negedge i_clk);
    chk("wrap_pc0", bus.o_pc, 32'hFFFF_FFFC);
    step();
    @(negedge i_clk);
    chk("wrap_pc1", bus.o_pc, 32'h0);
    step();
    ack_en = 1'b0;
    step();

    // 6: asynchronous reset with one entry buffered
    bus.i_ready = 1'b0;
    ack_en = 1'b1;
    step();
    ack_en = 1'b0;
    @(negedge i_clk);
    chk("t6_pre_valid", 32'(bus.o_inst_valid), 32'h1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.o_inst_valid), 32'h0);
    chk("t6_pc", bus.o_pc, 32'h0);
    chk("t6_req", 32'(bus.o_instruction_request), 32'h0);
    chk("t6_inst", bus.o_inst, 32'h0);
    chk("t6_inst_pc", bus.o_inst_pc, 32'h0);
    chk("t6_fault", 32'(bus.o_fetch_fault), 32'h0);
    step();
    i_rst_n = 1'b1;
    bus.i_ready = 1'b1;
    ack_en = 1'b1;
    exp_q.push_back(32'h0);
    @(negedge i_clk);
    chk("t6_first_pc", bus.o_pc, 32'h0);
    chk("t6_first_req", 32'(bus.o_instruction_request), 32'h1);
    step();
    ack_en = 1'b0;
    step(); step(); step();

    chk("sb_leftover", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
